// File: rtl/sseg_scan_mux.sv
// Time-multiplexes a double-buffered 4-digit BCD value onto a common-anode display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module sseg_scan_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  hex_out,
  output logic [3:0]  an,
  output logic        dp,
  output logic        pending,
  output logic        digit_err
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_prescaler;
  logic [1:0]       r_sel;
  logic [15:0]      r_disp_val;
  logic [3:0]       r_disp_dp;
  logic [15:0]      r_shadow_val;
  logic [3:0]       r_shadow_dp;
  logic             r_pending;

  logic             w_tick;
  logic             w_frame;
  logic [3:0]       w_nib;
  logic             w_dp_bit;
  logic             w_blank;
  logic             w_err;

  assign w_tick  = (r_prescaler == LP_LAST);
  assign w_frame = w_tick && (r_sel == 2'd3);

  // Prescaler, digit select, shadow capture and frame-boundary commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler  <= '0;
      r_sel        <= 2'd0;
      r_disp_val   <= 16'h0000;
      r_disp_dp    <= 4'b0000;
      r_shadow_val <= 16'h0000;
      r_shadow_dp  <= 4'b0000;
      r_pending    <= 1'b0;
    end else begin
      if (w_tick) begin
        r_prescaler <= '0;
        r_sel       <= r_sel + 2'd1;
      end else begin
        r_prescaler <= r_prescaler + CNT_W'(1);
      end

      // Commit reads the shadow as it was before any load in this same cycle.
      if (w_frame && r_pending) begin
        r_disp_val <= r_shadow_val;
        r_disp_dp  <= r_shadow_dp;
      end

      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
        r_pending    <= 1'b1;
      end else if (w_frame && r_pending) begin
        r_pending    <= 1'b0;
      end
    end
  end

  // Select the nibble and decimal-point request of the active digit.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    case (r_sel)
      2'd0: begin
        w_nib    = r_disp_val[3:0];
        w_dp_bit = r_disp_dp[0];
      end
      2'd1: begin
        w_nib    = r_disp_val[7:4];
        w_dp_bit = r_disp_dp[1];
      end
      2'd2: begin
        w_nib    = r_disp_val[11:8];
        w_dp_bit = r_disp_dp[2];
      end
      2'd3: begin
        w_nib    = r_disp_val[15:12];
        w_dp_bit = r_disp_dp[3];
      end
      default: begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
      end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is leading-zero when it and every digit above it are zero with no dp.
  always_comb begin
    w_blank = 1'b0;
    case (r_sel)
      2'd0:    w_blank = 1'b0;
      2'd1:    w_blank = (r_disp_val[15:4]  == 12'h000) && !r_disp_dp[1];
      2'd2:    w_blank = (r_disp_val[15:8]  == 8'h00)   && !r_disp_dp[2];
      2'd3:    w_blank = (r_disp_val[15:12] == 4'h0)    && !r_disp_dp[3];
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_err     = (w_nib > 4'd9);
  assign digit_err = w_err;
  assign dp        = ~w_dp_bit;
  assign pending   = r_pending;

  // Anode and nibble drive; invalid or blanked digits go dark with a safe code.
  always_comb begin
    an      = 4'b1111;
    hex_out = 4'h0;
    if (w_err || w_blank) begin
      an      = 4'b1111;
      hex_out = 4'h0;
    end else begin
      an      = ~(4'b0001 << r_sel);
      hex_out = w_nib;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux: directed vector table, frame-boundary
// load sequence, and randomized traffic against a cycle-count based reference model.
module tb_sseg_scan_mux;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        digit_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since reset plus digit/shadow contents.
  int unsigned m_cyc = 0;
  logic [15:0] m_disp = 16'h0, m_sh = 16'h0;
  logic [3:0]  m_dpd = 4'h0, m_shdp = 4'h0;
  logic        m_pend = 1'b0;
  bit          m_valid = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] AN2 = 4'hF;
  localparam logic [3:0] AN3 = 4'hF;
`else
  localparam logic [3:0] AN2 = 4'hB;
  localparam logic [3:0] AN3 = 4'h7;
`endif

  sseg_scan_mux #(.REFRESH_DIV(DIV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .hex_out(hex_out), .an(an), .dp(dp), .pending(pending), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {an,hex,dp,pend,err}=%b_%h_%b_%b_%b expected %b_%h_%b_%b_%b at t=%0t",
               name, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0], $time);
    end
  endtask

  function automatic logic [10:0] model_out();
    int         s;
    logic [3:0] nib, an_e, hex_e;
    logic       err, blank;
    s     = int'((m_cyc / DIV) % 4);
    nib   = 4'((m_disp >> (4 * s)) & 16'h000F);
    err   = (nib > 4'd9);
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (s > 0) && ((m_disp >> (4 * s)) == 16'h0000) && !m_dpd[s];
`endif
    if (err || blank) begin
      an_e  = 4'hF;
      hex_e = 4'h0;
    end else begin
      an_e  = 4'hF & ~(4'(1) << s);
      hex_e = nib;
    end
    return {an_e, hex_e, ~m_dpd[s], m_pend, err};
  endfunction

  function automatic logic [10:0] dut_out();
    return {an, hex_out, dp, pending, digit_err};
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
    reset = r; load = l; value = v; dp_in = d;
    @(posedge clk);
    if (r) begin
      m_cyc = 0; m_disp = 16'h0; m_dpd = 4'h0; m_sh = 16'h0; m_shdp = 4'h0;
      m_pend = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if ((m_cyc % (4 * DIV)) == (4 * DIV - 1) && m_pend) begin
        m_disp = m_sh; m_dpd = m_shdp; m_pend = 1'b0;
      end
      if (l) begin
        m_sh = v; m_shdp = d; m_pend = 1'b1;
      end
      m_cyc++;
    end
    #1;
    if (m_valid) chk("model", dut_out(), model_out());
  endtask

  typedef struct {
    logic        rst;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dpi;
    int          idle;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic        dp;
    logic        pend;
    logic        err;
  } vec_t;

  vec_t tbl[24];

  initial begin
    //            rst   ld    value     dp_in idle an    hex   dp    pend  err
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 0,  4'hE, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 0,  4'hE, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 2,  4'hE, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 0,  4'hD, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h1234, 4'h4, 0,  4'hD, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 9,  4'h7, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 0,  4'hE, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'hD, 4'h3, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'hB, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'h7, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h9A05, 4'h0, 2,  4'h7, 4'h1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 4'h0, 0,  4'hE, 4'h5, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'hD, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'hF, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'h7, 4'h9, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 16'h0042, 4'h0, 2,  4'h7, 4'h9, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 16'h0000, 4'h0, 0,  4'hE, 4'h2, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  4'hD, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  AN2,  4'h0, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  AN3,  4'h0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 16'h0000, 4'h0, 10, 4'hD, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 16'h1234, 4'h0, 0,  AN2,  4'h0, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 16'h0000, 4'h0, 0,  4'hE, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 16'hFFFF, 4'hF, 0,  4'hE, 4'h0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].val, tbl[i].dpi);
      for (int k = 0; k < tbl[i].idle; k++) step(1'b0, 1'b0, 16'h0000, 4'h0);
      chk($sformatf("vec%0d", i), dut_out(),
          {tbl[i].an, tbl[i].hex, tbl[i].dp, tbl[i].pend, tbl[i].err});
    end

    // Load on the frame-boundary cycle while another value is pending.
    step(1'b1, 1'b0, 16'h0000, 4'h0);
    step(1'b0, 1'b1, 16'h2222, 4'h0);
    for (int k = 0; k < 14; k++) step(1'b0, 1'b0, 16'h0000, 4'h0);
    step(1'b0, 1'b1, 16'h1111, 4'h0);
    chk("boundary_load_old", dut_out(), {4'hE, 4'h2, 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0000, 4'h0);
    chk("boundary_load_old_d1", dut_out(), {4'hE, 4'h2, 1'b1, 1'b1, 1'b0});
    step(1'b0, 1'b0, 16'h0000, 4'h0);
    chk("boundary_load_old_d1b", dut_out(), {4'hD, 4'h2, 1'b1, 1'b1, 1'b0});
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 16'h0000, 4'h0);
    chk("boundary_load_new", dut_out(), {4'hE, 4'h1, 1'b1, 1'b0, 1'b0});

    // Randomized traffic, including out-of-range nibbles and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
